arr_port_arbiter: RTL and testbench

Two-requester arbiter for one single-port synchronous array memory: 64-bit words, 1000 entries, one-cycle read latency. It sits between the memory and its two users, the host load/unload port (port 0) and the synthesized kernel datapath (port 1). It issues at most one access per cycle and round-robins between the ports. A port may lock the memory for a burst. Each read response is routed back to the port that issued it, and out-of-range addresses are flagged instead of reaching the memory.

---
 rtl/arr_port_arbiter_if.sv | 25 ++
 rtl/arr_port_arbiter.sv | 120 ++++++++++++
 tb/tb_arr_port_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arr_port_arbiter_if.sv
// rtl/arr_port_arbiter_if.sv - request/response bundle for one arbiter port
interface arr_port_arbiter_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 64
);
   logic              valid;
   logic              ready;
   logic              lock;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              rvalid;
   logic [DATA_W-1:0] rdata;
   logic              rerr;

   modport master (
      output valid, lock, we, addr, wdata,
      input  ready, rvalid, rdata, rerr
   );

   modport slave (
      input  valid, lock, we, addr, wdata,
      output ready, rvalid, rdata, rerr
   );
endinterface

// File: rtl/arr_port_arbiter.sv
// rtl/arr_port_arbiter.sv - two-port round-robin arbiter with lock for a single-port array memory
module arr_port_arbiter #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 64,
   parameter int DEPTH  = 1000
) (
   input  logic              clk,
   input  logic              rst_n,
   arr_port_arbiter_if.slave p0,
   arr_port_arbiter_if.slave p1,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              oor_flag
);

   typedef enum logic [1:0] {FREE, LOCK0, LOCK1} state_t;

   localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

   state_t state_q;
   logic   last_q;
   logic   tag_valid_q;
   logic   tag_port_q;
   logic   tag_err_q;
   logic   oor_q;

   logic              gnt0;
   logic              gnt1;
   logic              acc;
   logic              beat_we;
   logic              beat_lock;
   logic [ADDR_W-1:0] beat_addr;
   logic [DATA_W-1:0] beat_wdata;
   logic              beat_oor;
   logic              rvalid0;
   logic              rvalid1;

   // On a tie in FREE the port that was not accepted most recently wins.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (rst_n) begin
         case (state_q)
            FREE: begin
               if (p0.valid && p1.valid) begin
                  gnt0 = last_q;
                  gnt1 = !last_q;
               end else begin
                  gnt0 = p0.valid;
                  gnt1 = p1.valid;
               end
            end
            LOCK0:   gnt0 = p0.valid;
            LOCK1:   gnt1 = p1.valid;
            default: ;
         endcase
      end
   end

   assign acc        = gnt0 | gnt1;
   assign beat_we    = gnt1 ? p1.we    : p0.we;
   assign beat_lock  = gnt1 ? p1.lock  : p0.lock;
   assign beat_addr  = gnt1 ? p1.addr  : p0.addr;
   assign beat_wdata = gnt1 ? p1.wdata : p0.wdata;
   assign beat_oor   = acc && ({1'b0, beat_addr} >= DEPTH_L);

   assign p0.ready  = gnt0;
   assign p1.ready  = gnt1;
   assign mem_we    = acc && beat_we && !beat_oor;
   assign mem_addr  = beat_oor ? '0 : beat_addr;
   assign mem_wdata = beat_wdata;
   assign oor_flag  = oor_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= FREE;
         last_q      <= 1'b1;
         tag_valid_q <= 1'b0;
         tag_port_q  <= 1'b0;
         tag_err_q   <= 1'b0;
         oor_q       <= 1'b0;
      end else begin
         tag_valid_q <= acc && !beat_we;
         if (acc) begin
            last_q     <= gnt1;
            tag_port_q <= gnt1;
            tag_err_q  <= beat_oor;
         end
         if (beat_oor) begin
            oor_q <= 1'b1;
         end
         case (state_q)
            FREE: begin
               if (acc && beat_lock) begin
                  state_q <= gnt1 ? LOCK1 : LOCK0;
               end
            end
            LOCK0, LOCK1: begin
               if (acc && !beat_lock) begin
                  state_q <= FREE;
               end
            end
            default: state_q <= FREE;
         endcase
      end
   end

   // Out-of-range reads never touched memory, so their data is forced to zero.
   assign rvalid0   = tag_valid_q && !tag_port_q;
   assign rvalid1   = tag_valid_q && tag_port_q;
   assign p0.rvalid = rvalid0;
   assign p1.rvalid = rvalid1;
   assign p0.rerr   = rvalid0 && tag_err_q;
   assign p1.rerr   = rvalid1 && tag_err_q;
   assign p0.rdata  = (rvalid0 && !tag_err_q) ? mem_rdata : '0;
   assign p1.rdata  = (rvalid1 && !tag_err_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_arr_port_arbiter.sv
// tb/tb_arr_port_arbiter.sv - directed self-checking bench for arr_port_arbiter
module tb_arr_port_arbiter;

   localparam logic [63:0] NEG10 = 64'hFFFF_FFFF_FFFF_FFF6;

   logic        clk;
   logic        rst_n;
   logic        mem_we;
   logic [9:0]  mem_addr;
   logic [63:0] mem_wdata;
   logic [63:0] mem_rdata;
   logic        oor_flag;
   logic [63:0] mem [0:1023];

   int checks;
   int errors;

   arr_port_arbiter_if #(.ADDR_W(10), .DATA_W(64)) p0_if ();
   arr_port_arbiter_if #(.ADDR_W(10), .DATA_W(64)) p1_if ();

   arr_port_arbiter #(.ADDR_W(10), .DATA_W(64), .DEPTH(1000)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .p0        (p0_if),
      .p1        (p1_if),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .oor_flag  (oor_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int port, input logic v, input logic we, input logic lk,
                        input logic [9:0] a, input logic [63:0] d);
      if (port == 0) begin
         p0_if.valid = v; p0_if.we = we; p0_if.lock = lk; p0_if.addr = a; p0_if.wdata = d;
      end else begin
         p1_if.valid = v; p1_if.we = we; p1_if.lock = lk; p1_if.addr = a; p1_if.wdata = d;
      end
   endtask

   task automatic idle_all();
      drive(0, 1'b0, 1'b0, 1'b0, 10'd0, 64'd0);
      drive(1, 1'b0, 1'b0, 1'b0, 10'd0, 64'd0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(0, 1'b1, 1'b0, 1'b0, 10'd5, 64'd0);
      drive(1, 1'b1, 1'b0, 1'b0, 10'd5, 64'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if ({p0_if.ready, p1_if.ready, mem_we, p0_if.rvalid, p1_if.rvalid, oor_flag} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs cyc=%0d got rdy0=%b rdy1=%b we=%b rv0=%b rv1=%b oor=%b want all 0",
                     i, p0_if.ready, p1_if.ready, mem_we, p0_if.rvalid, p1_if.rvalid, oor_flag);
         end
         next_cycle();
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({p0_if.ready, p1_if.ready} !== 2'b10) begin
         errors++;
         $display("FAIL reset_first_grant got rdy0=%b rdy1=%b want 1 0", p0_if.ready, p1_if.ready);
      end
      next_cycle();
      idle_all();
      next_cycle();
   endtask

   // p1 writes -10 to addr 5 so last=1, then both read addr 5: grants 0,1,0,1.
   task automatic test_round_robin();
      logic exp_port [0:3];
      drive(1, 1'b1, 1'b1, 1'b0, 10'd5, NEG10);
      next_cycle();
      exp_port[0] = 1'b0; exp_port[1] = 1'b1; exp_port[2] = 1'b0; exp_port[3] = 1'b1;
      drive(0, 1'b1, 1'b0, 1'b0, 10'd5, 64'd0);
      drive(1, 1'b1, 1'b0, 1'b0, 10'd5, 64'd0);
      for (int i = 0; i < 5; i++) begin
         if (i == 4) idle_all();
         @(negedge clk);
         if (i < 4) begin
            checks++;
            if ({p0_if.ready, p1_if.ready} !== {!exp_port[i], exp_port[i]}) begin
               errors++;
               $display("FAIL rr_grant i=%0d got rdy0=%b rdy1=%b want port %0d", i,
                        p0_if.ready, p1_if.ready, exp_port[i]);
            end
         end
         if (i > 0) begin
            checks++;
            if (exp_port[i-1] == 1'b0) begin
               if (p0_if.rvalid !== 1'b1 || p1_if.rvalid !== 1'b0 || p0_if.rdata !== NEG10) begin
                  errors++;
                  $display("FAIL rr_resp0 i=%0d got rv0=%b rv1=%b rdata=%h want 1 0 %h", i,
                           p0_if.rvalid, p1_if.rvalid, p0_if.rdata, NEG10);
               end
            end else begin
               if (p1_if.rvalid !== 1'b1 || p0_if.rvalid !== 1'b0 || p1_if.rdata !== NEG10) begin
                  errors++;
                  $display("FAIL rr_resp1 i=%0d got rv1=%b rv0=%b rdata=%h want 1 0 %h", i,
                           p1_if.rvalid, p0_if.rvalid, p1_if.rdata, NEG10);
               end
            end
         end
         next_cycle();
      end
   endtask

   task automatic test_lock_burst();
      drive(0, 1'b1, 1'b0, 1'b0, 10'd5, 64'd0);
      next_cycle();
      for (int k = 0; k < 4; k++) begin
         drive(1, 1'b1, 1'b1, (k != 3), 10'(k), 64'hA5A5_0000_0000_0000 + 64'(k));
         drive(0, 1'b1, 1'b0, 1'b0, 10'd0, 64'd0);
         @(negedge clk);
         checks++;
         if (p0_if.ready !== 1'b0 || p1_if.ready !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 10'(k)) begin
            errors++;
            $display("FAIL lock_burst k=%0d got rdy0=%b rdy1=%b we=%b addr=%0d want 0 1 1 %0d", k,
                     p0_if.ready, p1_if.ready, mem_we, mem_addr, k);
         end
         next_cycle();
      end
      drive(1, 1'b0, 1'b0, 1'b0, 10'd0, 64'd0);
      for (int j = 0; j < 5; j++) begin
         if (j < 4) drive(0, 1'b1, 1'b0, 1'b0, 10'(j), 64'd0);
         else drive(0, 1'b0, 1'b0, 1'b0, 10'd0, 64'd0);
         @(negedge clk);
         if (j < 4) begin
            checks++;
            if (p0_if.ready !== 1'b1) begin
               errors++;
               $display("FAIL lock_release_grant j=%0d got rdy0=%b want 1", j, p0_if.ready);
            end
         end
         if (j > 0) begin
            checks++;
            if (p0_if.rvalid !== 1'b1 || p0_if.rdata !== 64'hA5A5_0000_0000_0000 + 64'(j-1)) begin
               errors++;
               $display("FAIL lock_readback addr=%0d got rv=%b rdata=%h want 1 %h", j-1,
                        p0_if.rvalid, p0_if.rdata, 64'hA5A5_0000_0000_0000 + 64'(j-1));
            end
         end
         next_cycle();
      end
   endtask

   // last=0 here, so p1 wins the opening tie and locks.
   task automatic test_lock_idle();
      drive(0, 1'b1, 1'b0, 1'b0, 10'd5, 64'd0);
      drive(1, 1'b1, 1'b1, 1'b1, 10'd10, 64'd77);
      @(negedge clk);
      checks++;
      if ({p0_if.ready, p1_if.ready} !== 2'b01) begin
         errors++;
         $display("FAIL lock_idle_take got rdy0=%b rdy1=%b want 0 1", p0_if.ready, p1_if.ready);
      end
      next_cycle();
      drive(1, 1'b0, 1'b0, 1'b0, 10'd0, 64'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (p0_if.ready !== 1'b0) begin
            errors++;
            $display("FAIL lock_idle_hold i=%0d got rdy0=%b want 0", i, p0_if.ready);
         end
         next_cycle();
      end
      drive(1, 1'b1, 1'b1, 1'b0, 10'd11, 64'd78);
      @(negedge clk);
      checks++;
      if ({p0_if.ready, p1_if.ready} !== 2'b01) begin
         errors++;
         $display("FAIL lock_idle_unlock got rdy0=%b rdy1=%b want 0 1", p0_if.ready, p1_if.ready);
      end
      next_cycle();
      drive(1, 1'b0, 1'b0, 1'b0, 10'd0, 64'd0);
      @(negedge clk);
      checks++;
      if (p0_if.ready !== 1'b1) begin
         errors++;
         $display("FAIL lock_idle_free got rdy0=%b want 1", p0_if.ready);
      end
      next_cycle();
      idle_all();
      next_cycle();
   endtask

   task automatic test_out_of_range();
      drive(0, 1'b1, 1'b1, 1'b0, 10'd1000, 64'hDEAD_BEEF_0000_0001);
      @(negedge clk);
      checks++;
      if (p0_if.ready !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 10'd0 || oor_flag !== 1'b0) begin
         errors++;
         $display("FAIL oor_write got rdy=%b we=%b addr=%0d oor=%b want 1 0 0 0",
                  p0_if.ready, mem_we, mem_addr, oor_flag);
      end
      next_cycle();
      drive(0, 1'b1, 1'b0, 1'b0, 10'd1023, 64'd0);
      @(negedge clk);
      checks++;
      if (p0_if.ready !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 10'd0 || oor_flag !== 1'b1) begin
         errors++;
         $display("FAIL oor_read got rdy=%b we=%b addr=%0d oor=%b want 1 0 0 1",
                  p0_if.ready, mem_we, mem_addr, oor_flag);
      end
      next_cycle();
      drive(0, 1'b1, 1'b0, 1'b0, 10'd0, 64'd0);
      @(negedge clk);
      checks++;
      if (p0_if.rvalid !== 1'b1 || p0_if.rerr !== 1'b1 || p0_if.rdata !== 64'd0 || p1_if.rvalid !== 1'b0) begin
         errors++;
         $display("FAIL oor_resp got rv=%b rerr=%b rdata=%h rv1=%b want 1 1 0 0",
                  p0_if.rvalid, p0_if.rerr, p0_if.rdata, p1_if.rvalid);
      end
      next_cycle();
      idle_all();
      @(negedge clk);
      checks++;
      if (p0_if.rvalid !== 1'b1 || p0_if.rerr !== 1'b0 || p0_if.rdata !== 64'hA5A5_0000_0000_0000 || oor_flag !== 1'b1) begin
         errors++;
         $display("FAIL oor_mem0_intact got rv=%b rerr=%b rdata=%h oor=%b want 1 0 a5a5000000000000 1",
                  p0_if.rvalid, p0_if.rerr, p0_if.rdata, oor_flag);
      end
      next_cycle();
   endtask

   // write A, read (A), write B during that response, read (B).
   task automatic test_back_to_back();
      logic [63:0] exp_d [0:3];
      exp_d[0] = 64'd0; exp_d[1] = 64'h1111_2222_3333_4444; exp_d[2] = 64'h1111_2222_3333_4444;
      exp_d[3] = 64'h5555_6666_7777_8888;
      for (int i = 0; i < 5; i++) begin
         case (i)
            0: drive(0, 1'b1, 1'b1, 1'b0, 10'd20, 64'h1111_2222_3333_4444);
            1: drive(0, 1'b1, 1'b0, 1'b0, 10'd20, 64'd0);
            2: drive(0, 1'b1, 1'b1, 1'b0, 10'd20, 64'h5555_6666_7777_8888);
            3: drive(0, 1'b1, 1'b0, 1'b0, 10'd20, 64'd0);
            default: idle_all();
         endcase
         @(negedge clk);
         if (i == 2 || i == 4) begin
            checks++;
            if (p0_if.rvalid !== 1'b1 || p0_if.rdata !== exp_d[i-1]) begin
               errors++;
               $display("FAIL b2b_read i=%0d got rv=%b rdata=%h want 1 %h", i,
                        p0_if.rvalid, p0_if.rdata, exp_d[i-1]);
            end
         end
         if (i == 2) begin
            checks++;
            if (mem_we !== 1'b1) begin
               errors++;
               $display("FAIL b2b_write_during_resp got we=%b want 1", mem_we);
            end
         end
         next_cycle();
      end
   endtask

   task automatic test_reset_mid_read();
      drive(0, 1'b1, 1'b0, 1'b0, 10'd5, 64'd0);
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if (p0_if.ready !== 1'b0 || mem_we !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_ready got rdy=%b we=%b want 0 0", p0_if.ready, mem_we);
      end
      next_cycle();
      rst_n = 1'b1;
      idle_all();
      @(negedge clk);
      checks++;
      if (p0_if.rvalid !== 1'b0 || p1_if.rvalid !== 1'b0 || oor_flag !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_rvalid got rv0=%b rv1=%b oor=%b want 0 0 0",
                  p0_if.rvalid, p1_if.rvalid, oor_flag);
      end
      next_cycle();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      idle_all();
      #1;
      test_reset();
      test_round_robin();
      test_lock_burst();
      test_lock_idle();
      test_out_of_range();
      test_back_to_back();
      test_reset_mid_read();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
